// File: rtl/dmem_ctrl_pkg.sv
// rtl/dmem_ctrl_pkg.sv - shared funct3 codes, FSM states and lane helpers for dmem_ctrl
package dmem_ctrl_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_REQ  = 2'd1,
    DM_DONE = 2'd2
  } dm_state_e;

  // Unsigned variants exist only for loads.
  function automatic logic f3_legal(input logic is_write, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !is_write;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    return 4'b0001 << off;
      SZ_H:    return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_replicate(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      SZ_B:    return {4{wd[7:0]}};
      SZ_H:    return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ctrl_load_extend.sv
// rtl/dmem_ctrl_load_extend.sv - lane select and sign/zero extension of a loaded word
module dmem_ctrl_load_extend
  import dmem_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] word_i,
  input  logic [1:0]            offset_i,
  input  logic [2:0]            funct3_i,
  output logic [DATA_WIDTH-1:0] result_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        signed_v;

  always_comb begin
    byte_v   = word_i[{offset_i, 3'b000} +: 8];
    half_v   = offset_i[1] ? word_i[31:16] : word_i[15:0];
    signed_v = !funct3_i[2];
    case (funct3_i[1:0])
      SZ_B:    result_o = {{24{signed_v & byte_v[7]}}, byte_v};
      SZ_H:    result_o = {{16{signed_v & half_v[15]}}, half_v};
      default: result_o = word_i;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - load/store responder: one byte-enabled bus request per access, core stalled meanwhile
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  stall,
  output logic                  fault,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [3:0]            bus_be,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_ready,
  input  logic [DATA_WIDTH-1:0] bus_rdata
);

  dm_state_e             state_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  bus_req_q;
  logic                  bus_we_q;
  logic [ADDR_WIDTH-1:0] bus_addr_q;
  logic [3:0]            bus_be_q;
  logic [DATA_WIDTH-1:0] bus_wdata_q;
  logic [1:0]            off_q;
  logic [2:0]            f3_q;
  logic [7:0]            cnt_q;
  logic                  tmo_fault_q;

  logic                  is_req;
  logic                  misalign;
  logic                  is_bad;
  logic                  accept;
  logic [1:0]            size;
  logic [8:0]            cnt_d;
  logic                  tmo_hit;
  logic [DATA_WIDTH-1:0] ext_word;

  always_comb begin
    size     = funct3[1:0];
    is_req   = mem_read | mem_write;
    misalign = (size == SZ_H && addr[0]) || (size == SZ_W && addr[1:0] != 2'b00);
    is_bad   = is_req && ((mem_read && mem_write) || !f3_legal(mem_write, funct3) || misalign);
    accept   = (state_q == DM_IDLE) && is_req && !is_bad;
    cnt_d    = {1'b0, cnt_q} + 9'd1;
    tmo_hit  = (cnt_d == 9'(TIMEOUT_CYCLES));
  end

  dmem_ctrl_load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_load_extend (
    .word_i   (bus_rdata),
    .offset_i (off_q),
    .funct3_i (f3_q),
    .result_o (ext_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= DM_IDLE;
      rdata_q     <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      off_q       <= '0;
      f3_q        <= '0;
      cnt_q       <= '0;
      tmo_fault_q <= 1'b0;
    end else begin
      tmo_fault_q <= 1'b0;
      case (state_q)
        DM_IDLE: begin
          if (accept) begin
            bus_req_q   <= 1'b1;
            bus_we_q    <= mem_write;
            bus_addr_q  <= {addr[ADDR_WIDTH-1:2], 2'b00};
            bus_be_q    <= byte_enables(size, addr[1:0]);
            bus_wdata_q <= lane_replicate(size, wdata);
            off_q       <= addr[1:0];
            f3_q        <= funct3;
            cnt_q       <= '0;
            state_q     <= DM_REQ;
          end
        end
        DM_REQ: begin
          if (bus_ready) begin
            bus_req_q <= 1'b0;
            if (!bus_we_q) rdata_q <= ext_word;
            state_q   <= DM_DONE;
          end else if (tmo_hit) begin
            // Fault is reported in DONE so it never coincides with stall.
            bus_req_q   <= 1'b0;
            rdata_q     <= '0;
            tmo_fault_q <= 1'b1;
            state_q     <= DM_DONE;
          end else begin
            cnt_q <= cnt_d[7:0];
          end
        end
        DM_DONE: state_q <= DM_IDLE;
        default: state_q <= DM_IDLE;
      endcase
    end
  end

  assign stall     = !rst && (accept || state_q == DM_REQ);
  assign fault     = !rst && ((state_q == DM_IDLE && is_bad) || tmo_fault_q);
  assign rdata     = rdata_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - directed bench for dmem_ctrl with an rdata scoreboard
module tb_dmem_ctrl;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, rdata;
  logic        stall, fault, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  dmem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .fault(fault),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input int ready_at,
                        input logic [31:0] rword, input logic [31:0] exp_addr,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd,
                        input logic [31:0] exp_rd);
    logic tmo;
    logic [31:0] exp;
    tmo = (ready_at < 0);
    sb_q.push_back(exp_rd);
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    bus_ready = 1'b0; bus_rdata = rword;
    @(negedge clk);
    chk("accept_stall", {31'd0, stall}, 32'd1);
    chk("accept_bus_req", {31'd0, bus_req}, 32'd0);
    chk("accept_fault", {31'd0, fault}, 32'd0);
    next_cycle();
    for (int k = 0; k < TMO; k++) begin
      bus_ready = (k == ready_at);
      @(negedge clk);
      chk("req_bus_req", {31'd0, bus_req}, 32'd1);
      chk("req_stall", {31'd0, stall}, 32'd1);
      chk("req_fault", {31'd0, fault}, 32'd0);
      chk("req_bus_addr", bus_addr, exp_addr);
      chk("req_bus_be", {28'd0, bus_be}, {28'd0, exp_be});
      chk("req_bus_we", {31'd0, bus_we}, {31'd0, wr});
      chk("req_bus_wdata", bus_wdata, exp_wd);
      next_cycle();
      if (k == ready_at) break;
    end
    bus_ready = 1'b0;
    bus_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    chk("done_stall", {31'd0, stall}, 32'd0);
    chk("done_bus_req", {31'd0, bus_req}, 32'd0);
    chk("done_fault", {31'd0, fault}, {31'd0, tmo});
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      exp = sb_q.pop_front();
      chk("done_rdata", rdata, exp);
    end
    next_cycle();
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    chk("idle_stall", {31'd0, stall}, 32'd0);
    chk("idle_fault", {31'd0, fault}, 32'd0);
    chk("idle_bus_req", {31'd0, bus_req}, 32'd0);
    chk("idle_rdata_hold", rdata, exp_rd);
    next_cycle();
  endtask

  task automatic bad_access(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a);
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = 32'h1234_5678;
    @(negedge clk);
    chk("bad_fault", {31'd0, fault}, 32'd1);
    chk("bad_stall", {31'd0, stall}, 32'd0);
    chk("bad_bus_req", {31'd0, bus_req}, 32'd0);
    next_cycle();
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    chk("bad_fault_pulse", {31'd0, fault}, 32'd0);
    chk("bad_bus_req_after", {31'd0, bus_req}, 32'd0);
    chk("bad_stall_after", {31'd0, stall}, 32'd0);
    next_cycle();
  endtask

  initial begin
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
    addr = '0; wdata = '0; bus_ready = 1'b0; bus_rdata = '0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("rst_stall_forced", {31'd0, stall}, 32'd0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_bus_we", {31'd0, bus_we}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_be", {28'd0, bus_be}, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    next_cycle();

    // rd wr f3 addr wdata ready_at rword exp_addr exp_be exp_wdata exp_rdata
    access(0, 1, 3'b010, 32'h100, 32'hDEAD_BEEF, 0, 32'h0, 32'h100, 4'b1111, 32'hDEAD_BEEF, 32'h0);
    access(0, 1, 3'b000, 32'h103, 32'h0000_00A5, 1, 32'h0, 32'h100, 4'b1000, 32'hA5A5_A5A5, 32'h0);
    access(1, 0, 3'b000, 32'h102, 32'h0, 0, 32'h12F0_3456, 32'h100, 4'b0100, 32'h0, 32'hFFFF_FFF0);
    access(1, 0, 3'b100, 32'h102, 32'h0, 2, 32'h12F0_3456, 32'h100, 4'b0100, 32'h0, 32'h0000_00F0);
    access(1, 0, 3'b001, 32'h102, 32'h0, 1, 32'h12F0_3456, 32'h100, 4'b1100, 32'h0, 32'h0000_12F0);
    access(1, 0, 3'b101, 32'h100, 32'h0, 0, 32'h8001_ABCD, 32'h100, 4'b0011, 32'h0, 32'h0000_ABCD);
    access(1, 0, 3'b001, 32'h000, 32'h0, 0, 32'h8001_ABCD, 32'h000, 4'b0011, 32'h0, 32'hFFFF_ABCD);
    access(1, 0, 3'b000, 32'h207, 32'h0, 3, 32'h80AA_BBCC, 32'h204, 4'b1000, 32'h0, 32'hFFFF_FF80);
    access(1, 0, 3'b010, 32'h104, 32'h0, 0, 32'h89AB_CDEF, 32'h104, 4'b1111, 32'h0, 32'h89AB_CDEF);
    access(0, 1, 3'b001, 32'h202, 32'h5555_1234, 0, 32'h0, 32'h200, 4'b1100, 32'h1234_1234, 32'h89AB_CDEF);

    bad_access(1, 0, 3'b010, 32'h101);
    bad_access(0, 1, 3'b001, 32'h001);
    bad_access(1, 0, 3'b011, 32'h100);
    bad_access(1, 1, 3'b010, 32'h100);
    bad_access(0, 1, 3'b100, 32'h100);

    bus_ready = 1'b1; bus_rdata = 32'h7777_7777;
    next_cycle();
    bus_ready = 1'b0;
    @(negedge clk);
    chk("stray_ready_bus_req", {31'd0, bus_req}, 32'd0);
    chk("stray_ready_rdata", rdata, 32'h89AB_CDEF);
    next_cycle();

    access(1, 0, 3'b010, 32'h108, 32'h0, -1, 32'h1111_1111, 32'h108, 4'b1111, 32'h0, 32'h0);

    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h110; bus_ready = 1'b0;
    @(negedge clk);
    chk("rstreq_accept_stall", {31'd0, stall}, 32'd1);
    next_cycle();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rstreq_bus_req", {31'd0, bus_req}, 32'd1);
      next_cycle();
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rstreq_stall_forced", {31'd0, stall}, 32'd0);
    chk("rstreq_fault_forced", {31'd0, fault}, 32'd0);
    next_cycle();
    rst = 1'b0; mem_read = 1'b0;
    @(negedge clk);
    chk("rstreq_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rstreq_bus_addr", bus_addr, 32'd0);
    chk("rstreq_bus_be", {28'd0, bus_be}, 32'd0);
    chk("rstreq_stall", {31'd0, stall}, 32'd0);
    next_cycle();

    access(1, 0, 3'b010, 32'h10C, 32'h0, 0, 32'h0000_0042, 32'h10C, 4'b1111, 32'h0, 32'h0000_0042);

    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory responder for the single-issue core. It accepts the `mem_read`/`mem_write` strobes that the control decoder issues for LOAD/STORE instructions, together with funct3, address and store data. It converts each access into one word-aligned, byte-enabled request on a ready-handshaked memory bus and holds the core stalled until that request completes. For loads it returns a sign- or zero-extended result on the WB_MEM writeback path.

## Interface
- `DATA_WIDTH`, 32, core and bus data width; only 32 is supported.
- `ADDR_WIDTH`, 32, byte address width.
- `TIMEOUT_CYCLES`, 255, maximum number of REQ cycles without `bus_ready` before the access is aborted; range 1..255.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_read`  in  1  load strobe from the control decoder.
- `mem_write`  in  1  store strobe from the control decoder.
- `funct3`  in  3  instr[14:12]; sets access size and signedness.
- `addr`  in  ADDR_WIDTH  byte address (ALU result).
- `wdata`  in  DATA_WIDTH  store data (rs2).
- `rdata`  out  DATA_WIDTH  extended load result, registered.
- `stall`  out  1  freezes the core pipeline while an access is in flight.
- `fault`  out  1  one-cycle pulse on misaligned, illegal or timed-out access.
- `bus_req`  out  1  bus request.
- `bus_we`  out  1  1 = write, 0 = read.
- `bus_addr`  out  ADDR_WIDTH  word address, with bits [1:0] always 0.
- `bus_be`  out  4  byte enables.
- `bus_wdata`  out  DATA_WIDTH  lane-replicated store data.
- `bus_ready`  in  1  completion from memory; for reads, `bus_rdata` is valid in the same cycle.
- `bus_rdata`  in  DATA_WIDTH  read word.

## Operation
FSM states: IDLE, REQ, DONE.

IDLE
- A request is `mem_read | mem_write`.
- A request is faulted when any of the following holds:
  - `mem_read & mem_write`;
  - funct3 is not one of LB/LH/LW/LBU/LHU for a read, or SB/SH/SW for a write;
  - a halfword access has `addr[0]=1`;
  - a word access has `addr[1:0]!=0`.
- Faulted request: `fault=1` for this cycle, `stall=0`, no bus access, stay in IDLE.
- Legal request: `stall=1` combinationally. Latch `bus_we`, `bus_addr={addr[31:2],2'b00}`, `bus_be`, `bus_wdata`, `addr[1:0]` and funct3. Clear the timeout counter and go to REQ.
- Byte enables:
  - byte: `4'b0001<<addr[1:0]`;
  - half: `addr[1] ? 4'b1100 : 4'b0011`;
  - word: `4'b1111`.
- Store data:
  - byte: `{4{wdata[7:0]}}`;
  - half: `{2{wdata[15:0]}}`;
  - word: `wdata`.

REQ
- `bus_req=1` and `stall=1`. Address, `bus_we`, `bus_be` and `bus_wdata` stay stable.
- `bus_ready=1`:
  - for a read, select the lane given by the latched `addr[1:0]` from `bus_rdata`, then sign-extend (LB/LH) or zero-extend (LBU/LHU) and register into `rdata`;
  - for a write, `rdata` is unchanged;
  - go to DONE.
- Otherwise the counter increments. When it reaches `TIMEOUT_CYCLES`: `fault` pulses, `bus_req` drops, `rdata` is cleared to 0, and the FSM goes to DONE.

DONE
- `bus_req=0`, `stall=0`; the core advances at the end of this cycle.
- Always return to IDLE. Requests seen during DONE are ignored; the pipeline presents the next instruction in the following IDLE cycle.

## Timing
- Best case: a 3-cycle access (IDLE accept, REQ with `bus_ready`, DONE).
  - `bus_req` rises the cycle after the accept.
  - `rdata` is valid from DONE and holds until the next load completes.
- Each REQ cycle without `bus_ready` adds one cycle.
- A timeout ends the access after exactly `TIMEOUT_CYCLES` REQ cycles.
- `bus_ready` is ignored while `bus_req=0`.
- `fault` and `stall` are never 1 in the same cycle.
- Reset values: state IDLE, and every output is 0 (`rdata`, `bus_*`, `stall`, `fault`).
  - `stall` is forced to 0 while `rst=1`.
- `rst` during REQ: `bus_req` is 0 in the next cycle and the outstanding transaction is abandoned. The bus must tolerate a dropped request.

## Structure
- `defines.vh` gains:
  - funct3 size codes `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`;
  - FSM state encodings `DM_IDLE`, `DM_REQ`, `DM_DONE`.
- One sub-module is natural: `load_extend`, which is combinational. It takes the word, offset and funct3 and returns the extended result; the writeback path also reuses it.

## Test plan
- SW at `addr=0x100`, `wdata=0xDEADBEEF`, `bus_ready` on the first REQ cycle -> `bus_addr=0x100`, `bus_be=1111`, `bus_we=1`; `stall` high for 2 cycles, low in DONE.
- SB at `0x103`, `wdata=0x000000A5` -> `bus_be=1000`, `bus_wdata=0xA5A5A5A5`.
- LB and LBU at `0x102`, `bus_rdata=0x12F03456` -> `rdata=0xFFFFFFF0` and `rdata=0x000000F0`; LH at `0x102` -> `rdata=0x000012F0`.
- LW at `0x101`, SH at `0x001`, and `funct3=3'b011` with `mem_read` -> `fault` pulses for 1 cycle, `bus_req` never rises, `stall` stays 0.
- LW with `bus_ready` held low and `TIMEOUT_CYCLES=4` -> `fault` pulses after 4 REQ cycles, `rdata=0`, `stall` drops in DONE.
- `bus_ready` delayed 3 cycles, then `rst` asserted in REQ -> all outputs 0 the next cycle and the state returns to IDLE.
